mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the byte-addressed, big-endian word memory port. Sits between the
//  multicycle MIPS datapath and the memory, turning one load/store request
//  (LW/LH/LHU/LB/LBU/SW/SH/SB) into memread/memwrite cycles. Sub-word stores use read-modify-write.
//  Also does size/sign extraction, alignment checks and bounds checks, and returns a one-cycle ack.
// PARAMETERS
//  ADDR_W     6   byte-address width of datapath and memory port
//  MEM_BYTES  51  bytes implemented in memory; highest legal word base is the largest multiple of 4 with base+3 <= MEM_BYTES-1
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  reset      in   1       synchronous, active-high
//  req        in   1       request strobe; sampled only in IDLE
//  we         in   1       1 = store, 0 = load
//  size       in   2       00 byte, 01 halfword, 10 word, 11 illegal
//  sign_ext   in   1       loads only: 1 sign-extends, 0 zero-extends sub-word data
//  addr       in   ADDR_W  byte address
//  wdata      in   32      store data, right-justified for SB/SH
//  busy       out  1       high whenever state != IDLE
//  ack        out  1       one-cycle completion pulse
//  err        out  1       valid with ack; 1 = misaligned/illegal size/out of range
//  rdata      out  32      load result; updated only at a successful load's ack
//  mem_addr   out  ADDR_W  word base {addr[ADDR_W-1:2],2'b00} to memory
//  mem_wdata  out  32      word to memory
//  mem_read   out  1       memory read enable (memory read path is combinational)
//  mem_write  out  1       memory write enable (memory commits on posedge)
//  mem_rdata  in   32      word from memory; byte at base+0 = bits[31:24]
// BEHAVIOUR
//  - Reset values: state IDLE, busy/ack/err/mem_read/mem_write=0, rdata=0, mem_addr=0, mem_wdata=0.
//  - States: IDLE, READ, WRITE, RMW_RD, RMW_WR, DONE. mem_read/mem_write are decoded from the state register only.
//  - IDLE: req=1 latches we,size,sign_ext,addr,wdata. Next state: error ? DONE(err=1) : load ? READ :
//    SW ? WRITE : RMW_RD. Request inputs are ignored in every other state; nothing is queued.
//  - Error: size=11; halfword with addr[0]=1; word with addr[1:0]!=0; word base beyond the legal range.
//    No mem_read/mem_write is issued for an errored request, and rdata is not changed.
//  - READ: mem_read=1; mem_rdata captured at the edge; next DONE.
//  - WRITE: mem_write=1 for exactly one cycle with mem_wdata=wdata; next DONE.
//  - RMW_RD: mem_read=1; word captured; next RMW_WR.
//  - RMW_WR: mem_write=1 for one cycle with merged word. SB replaces byte k=addr[1:0] at
//    bits[31-8k -: 8] with wdata[7:0]. SH replaces [31:16] (off 0) or [15:0] (off 2) with wdata[15:0].
//  - DONE: ack=1 for one cycle (err as decided); next IDLE unconditionally.
//    A req in DONE is not accepted; minimum spacing is one IDLE cycle.
//  - Load extraction: byte k = word[31-8k -: 8]; half offset 0 -> [31:16], offset 2 -> [15:0].
//    Result is sign- or zero-extended to 32 bits per sign_ext; LW ignores sign_ext.
//  - Latency from req cycle to ack: error 1, load/SW 2, SB/SH 3.
//  - mem_read and mem_write are never high in the same cycle.
//  - Reset mid-operation: next state is IDLE, and no ack is produced for the aborted request.
//    A write cycle coinciding with reset still commits at that edge; no later access is issued.
//    Reset during RMW_RD produces no write.
// TESTING  (memory preloaded: word0=0x00430822, word4=0x8CA40006, word24=0x11111111)
//  1 LW addr=4 -> mem_read one cycle; ack 2 cycles after req; rdata=0x8CA40006; err=0.
//  2 LB addr=4 sign_ext=1 -> 0xFFFFFF8C; LBU addr=4 -> 0x0000008C; LH addr=6 -> 0x00000006;
//    LHU addr=0 -> 0x00000043.
//  3 SB addr=25 wdata=0x000000AB -> one mem_read, then one mem_write of 0x11AB1111 to mem_addr 24;
//    ack 3 cycles after req; LW 24 then returns 0x11AB1111.
//    SH addr=26 wdata=0xBEEF -> 0x11ABBEEF.
//  4 LW addr=2, SH addr=1, size=11, and LW addr=48 -> each acks after 1 cycle with err=1;
//    mem_read=mem_write=0 throughout; rdata unchanged.
//  5 req held high continuously through an LW -> second request accepted only in the IDLE cycle
//    after DONE; exactly one ack per accepted op; busy=1 in all non-IDLE cycles.
//  6 SB issued, reset asserted during RMW_RD -> mem_write never asserted; next cycle IDLE,
//    ack=0, busy=0; word24 unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// Initiator side of the big-endian word memory port: turns one load/store request
// into memread/memwrite cycles, with sub-word extraction, RMW stores and range checks.
module mem_access_unit #(
  parameter int ADDR_W    = 6,
  parameter int MEM_BYTES = 51
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Highest word base whose four bytes all lie inside the implemented memory.
  localparam int                LAST_BASE   = ((MEM_BYTES - 4) / 4) * 4;
  localparam logic [ADDR_W-1:0] LAST_BASE_A = ADDR_W'(LAST_BASE);

  logic [2:0]        r_state;
  logic              r_we;
  logic              r_sext;
  logic              r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic [31:0]       r_rdata;

  logic [ADDR_W-1:0] w_in_base;
  logic              w_req_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  assign w_in_base = {addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    w_req_err = 1'b0;
    case (size)
      2'b11:   w_req_err = 1'b1;
      2'b01:   w_req_err = addr[0];
      2'b10:   w_req_err = (addr[1:0] != 2'b00);
      default: w_req_err = 1'b0;
    endcase
    if (w_in_base > LAST_BASE_A) w_req_err = 1'b1;
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'b00:   w_byte = mem_rdata[31:24];
      2'b01:   w_byte = mem_rdata[23:16];
      2'b10:   w_byte = mem_rdata[15:8];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_addr[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (r_size)
      2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_merged = r_word;
    if (r_size == 2'b00) begin
      case (r_addr[1:0])
        2'b00:   w_merged[31:24] = r_wdata[7:0];
        2'b01:   w_merged[23:16] = r_wdata[7:0];
        2'b10:   w_merged[15:8]  = r_wdata[7:0];
        default: w_merged[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merged[15:0] = r_wdata[15:0];
    end else begin
      w_merged[31:16] = r_wdata[15:0];
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign ack       = (r_state == S_DONE);
  assign err       = ack & r_err;
  assign rdata     = r_rdata;
  assign mem_read  = (r_state == S_READ) | (r_state == S_RMW_RD);
  assign mem_write = (r_state == S_WRITE) | (r_state == S_RMW_WR);
  assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = (r_state == S_WRITE)  ? r_wdata  :
                     (r_state == S_RMW_WR) ? w_merged : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_size  <= size;
            r_sext  <= sign_ext;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_err   <= w_req_err;
            if (w_req_err)          r_state <= S_DONE;
            else if (!we)           r_state <= S_READ;
            else if (size == 2'b10) r_state <= S_WRITE;
            else                    r_state <= S_RMW_RD;
          end
        end
        S_READ: begin
          // Result is formatted here so rdata is already valid while ack is high.
          r_rdata <= w_load;
          r_state <= S_DONE;
        end
        S_WRITE:  r_state <= S_DONE;
        S_RMW_RD: begin
          r_word  <= mem_rdata;
          r_state <= S_RMW_WR;
        end
        S_RMW_WR: r_state <= S_DONE;
        S_DONE:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule
